uart_rx: RTL and testbench

Serial UART receiver feeding the byte FIFO on the CPU's console input path. It synchronises the asynchronous RX line, finds start bits, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and pushes each good byte into the FIFO write port with a request/acknowledge handshake. Receive errors are reported as single-cycle pulses for the status register.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width and default bit period.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1) pushing bytes into the console FIFO via a set/ack handshake.
// Define UART_RX_PARITY_EN for an 8E1 frame with even-parity check and o_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_rx,
  input  logic                 i_ack,
  output logic                 o_set,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_busy,
  output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic                 o_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 baud_hit;
  logic                 deliver;
  logic                 frame_err_d, frame_err_q;
  logic                 overrun_d, overrun_q;
  logic                 set_d, set_q;
  logic [DATA_BITS-1:0] data_d, data_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_d, par_bad_q;
  logic                 parity_err_d, parity_err_q;
`endif

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rx),
    .o_q  (rx_s)
  );

  // START waits half a bit to land mid-bit; every later sample is one full bit on.
  assign baud_hit = (baud_q == ((state_q == START) ? HALF_LAST : FULL_LAST));

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (!i_en) begin
      state_d = IDLE;
      baud_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s) begin
            state_d = START;
            baud_d  = '0;
            idx_d   = '0;
          end
        end
        START: begin
          if (baud_hit) begin
            baud_d  = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_hit) begin
            baud_d         = '0;
            shift_d[idx_q] = rx_s;
            if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_hit) begin
            baud_d       = '0;
            par_bad_d    = (^shift_q) != rx_s;
            parity_err_d = (^shift_q) != rx_s;
            state_d      = STOP;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_hit) begin
            baud_d  = '0;
            state_d = IDLE;
            if (!rx_s) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (!par_bad_q) deliver = 1'b1;
`else
            else deliver = 1'b1;
`endif
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The ack clear is applied before the delivery test, so a same-cycle ack frees the slot.
  always_comb begin
    set_d     = set_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (i_en) begin
      if (i_ack) set_d = 1'b0;
      if (deliver) begin
        if (!set_d) begin
          set_d  = 1'b1;
          data_d = shift_q;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      baud_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      set_q        <= 1'b0;
      data_q       <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_prev_q    <= rx_s;
      state_q      <= state_d;
      baud_q       <= baud_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      set_q        <= set_d;
      data_q       <= data_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign o_set       = set_q;
  assign o_data      = data_q;
  assign o_busy      = (state_q != IDLE);
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model feeds an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic       set_o;
  logic [7:0] data_o;
  logic       busy_o;
  logic       fe_o;
  logic       ov_o;
  logic       pe_o;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_rx        (rx),
    .i_ack       (ack),
    .o_set       (set_o),
    .o_data      (data_o),
    .o_busy      (busy_o),
    .o_frame_err (fe_o),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(pe_o),
`endif
    .o_overrun   (ov_o)
  );
`ifndef UART_RX_PARITY_EN
  assign pe_o = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int got_fe = 0, got_ov = 0, got_pe = 0;
  int writes = 0, set_hi = 0, busy_hi = 0, age = 0;
  logic hold = 1'b0;
  logic pending = 1'b0;
  logic prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;
  logic [7:0] mon_b;

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
    end
  endtask

  // FIFO model (acks one cycle after o_set is seen) plus pulse/scoreboard monitor.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      ack = 1'b0;
      age = 0;
      prev_fe = 1'b0;
      prev_ov = 1'b0;
      prev_pe = 1'b0;
    end else begin
      if (set_o) set_hi++;
      if (busy_o) busy_hi++;
      if (fe_o) begin got_fe++; chk("frame_err_width", int'(prev_fe), 0); end
      if (ov_o) begin got_ov++; chk("overrun_width", int'(prev_ov), 0); end
      if (pe_o) begin got_pe++; chk("parity_err_width", int'(prev_pe), 0); end
      prev_fe = fe_o;
      prev_ov = ov_o;
      prev_pe = pe_o;
      if (ack) begin
        ack = 1'b0;
        age = 0;
      end else if (set_o) begin
        if (!hold && age >= 1) begin
          if (exp_q.size() == 0) begin
            chk("write_unexpected", int'(data_o), -1);
          end else begin
            mon_b = exp_q.pop_front();
            chk("write_data", int'(data_o), int'(mon_b));
          end
          $display("fifo write 0x%02h", data_o);
          writes++;
          ack = 1'b1;
        end else begin
          age++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return ^d;
  endfunction

  // Frame-level reference: decides the outcome from data, stop and parity alone.
  task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    logic par_ok;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = (par_b == par_of(d));
    if (!par_ok) exp_pe++;
`endif
    if (!stop_b) exp_fe++;
    else if (par_ok) begin
      if (hold && pending) exp_ov++;
      else begin
        exp_q.push_back(d);
        pending = hold;
      end
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int gap);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(C);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_b;
    tick(C);
`endif
    rx = stop_b;
    tick(C);
    rx = 1'b1;
    tick(gap);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int gap);
    $display("send 0x%02h stop=%0b par=%0b", d, stop_b, par_b);
    model_frame(d, stop_b, par_b);
    drive_frame(d, stop_b, par_b, gap);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_frame_err_cnt"}, got_fe, exp_fe);
    chk({tag, "_overrun_cnt"}, got_ov, exp_ov);
    chk({tag, "_parity_err_cnt"}, got_pe, exp_pe);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    chk({tag, "_pending_bytes"}, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [7:0] d;
    logic stop_b, par_b;

    tick(3);
    chk("rst_set", int'(set_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_errs", int'({fe_o, ov_o, pe_o}), 0);
    rst = 1'b0;
    tick(4);

    // Clean 0x55: one write, o_set high two cycles
    set_hi = 0;
    w0 = writes;
    send_frame(8'h55, 1'b1, par_of(8'h55), 4);
    wait_drain("s55");
    tick(4);
    chk("s55_set_cycles", set_hi, 2);
    chk("s55_writes", writes, w0 + 1);
    checkpoint("s55");

    // Half-bit glitch on idle line
    busy_hi = 0;
    set_hi = 0;
    rx = 1'b0;
    tick(C / 2);
    rx = 1'b1;
    tick(3 * C);
    chk("glitch_busy_cycles", busy_hi, C / 2);
    chk("glitch_busy_now", int'(busy_o), 0);
    chk("glitch_set_cycles", set_hi, 0);
    checkpoint("glitch");

    // Bad stop bit
    set_hi = 0;
    send_frame(8'hA3, 1'b0, par_of(8'hA3), 4);
    tick(4);
    chk("ferr_set_cycles", set_hi, 0);
    checkpoint("ferr");

    // Ack held off across two frames
    hold = 1'b1;
    w0 = writes;
    send_frame(8'h11, 1'b1, par_of(8'h11), 2);
    send_frame(8'h22, 1'b1, par_of(8'h22), 4);
    tick(4);
    chk("ovr_data_held", int'(data_o), 8'h11);
    chk("ovr_set_held", int'(set_o), 1);
    checkpoint("ovr");
    hold = 1'b0;
    pending = 1'b0;
    wait_drain("ovr");
    tick(4);
    chk("ovr_writes", writes, w0 + 1);
    chk("ovr_set_cleared", int'(set_o), 0);

    // Reset during data bit 4 of 0xFF, with a byte pending
    hold = 1'b1;
    send_frame(8'h5A, 1'b1, par_of(8'h5A), 2);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(C);
    end
    tick(2);
    chk("mid_busy", int'(busy_o), 1);
    chk("mid_set_pending", int'(set_o), 1);
    rst = 1'b1;
    #1;
    chk("arst_set", int'(set_o), 0);
    chk("arst_data", int'(data_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_errs", int'({fe_o, ov_o, pe_o}), 0);
    exp_q.delete();
    pending = 1'b0;
    hold = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    send_frame(8'h3C, 1'b1, par_of(8'h3C), 4);
    wait_drain("after_rst");
    checkpoint("after_rst");

    // Disabled block ignores a whole frame
    w0 = writes;
    en = 1'b0;
    drive_frame(8'h99, 1'b1, par_of(8'h99), 4);
    en = 1'b1;
    tick(4);
    chk("disabled_writes", writes, w0);
    checkpoint("disabled");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 4);
    send_frame(8'h07, 1'b1, 1'b1, 4);
    wait_drain("parity");
    tick(4);
    checkpoint("parity");
`endif

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      stop_b = ($urandom_range(0, 7) != 0);
      par_b = par_of(d) ^ ($urandom_range(0, 5) == 0);
      send_frame(d, stop_b, par_b, int'($urandom_range(1, 6)));
    end
    tick(8);
    wait_drain("random");
    checkpoint("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
